// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 compression control path.
// Holds the FSM state enum, default round geometry, the IV and the K round-constant table.
package sha256_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StRound,
        StFinal,
        StDone
    } state_e;

    localparam int unsigned RoundsDefault     = 64;
    localparam int unsigned SchedWordsDefault = 16;
    localparam int unsigned CntWDefault       = 6;

    localparam logic [0:7][31:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] k_word(input logic [5:0] idx);
        return K[idx];
    endfunction

endpackage

// File: rtl/sha256_round_cnt.sv
// Round counter for the SHA-256 controller: synchronous clear, enable, and a terminal flag
// raised when the count reaches ROUNDS-1. The count saturates there rather than wrapping.
module sha256_round_cnt
    import sha256_pkg::*;
#(
    parameter int unsigned CNT_W  = CntWDefault,
    parameter int unsigned ROUNDS = RoundsDefault
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             term_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             term;

    assign term = (cnt_q == CNT_W'(ROUNDS - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !term) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign term_o = term;

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 round controller: accepts a block, sequences INIT, ROUNDS rounds and the H update.
// Define SHA_CTRL_MULTIBLOCK_EN to honour blk_last and chain H across non-final blocks.
module sha256_round_ctrl
    import sha256_pkg::*;
#(
    parameter int unsigned ROUNDS      = RoundsDefault,
    parameter int unsigned SCHED_WORDS = SchedWordsDefault,
    parameter int unsigned CNT_W       = CntWDefault
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             blk_valid,
    output logic             blk_ready,
`ifdef SHA_CTRL_MULTIBLOCK_EN
    input  logic             blk_last,
`endif
    output logic             start,
    output logic             sel_A,
    output logic             h_init,
    output logic             round_en,
    output logic [CNT_W-1:0] round_idx,
    output logic             sel_W,
    output logic             h_update,
    output logic             digest_valid,
    input  logic             out_ready
);

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             first_blk_q, first_blk_d;
    logic             blk_last_in;
    logic [CNT_W-1:0] cnt;
    logic             cnt_term;

`ifdef SHA_CTRL_MULTIBLOCK_EN
    assign blk_last_in = blk_last;
`else
    assign blk_last_in = 1'b1;
`endif

    sha256_round_cnt #(
        .CNT_W  (CNT_W),
        .ROUNDS (ROUNDS)
    ) u_round_cnt (
        .clk_i  (CLK),
        .rst_ni (RST),
        .clr_i  (state_q != StRound),
        .en_i   (state_q == StRound),
        .cnt_o  (cnt),
        .term_o (cnt_term)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        first_blk_d = first_blk_q;
        unique case (state_q)
            StIdle: begin
                if (blk_valid) begin
                    state_d = StInit;
                    last_d  = blk_last_in;
                end
            end
            StInit:  state_d = StRound;
            StRound: begin
                if (cnt_term) begin
                    state_d = StFinal;
                end
            end
            StFinal: begin
                // The block after a final one restarts from the IV.
                first_blk_d = last_q;
                state_d     = last_q ? StDone : StIdle;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= StIdle;
            last_q      <= 1'b0;
            first_blk_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            first_blk_q <= first_blk_d;
        end
    end

    // Moore decode: outputs depend on registered state and counter only.
    always_comb begin
        blk_ready    = 1'b0;
        start        = 1'b0;
        sel_A        = 1'b0;
        h_init       = 1'b0;
        round_en     = 1'b0;
        round_idx    = '0;
        sel_W        = 1'b0;
        h_update     = 1'b0;
        digest_valid = 1'b0;
        unique case (state_q)
            StIdle: blk_ready = 1'b1;
            StInit: begin
                start  = 1'b1;
                sel_A  = 1'b1;
                h_init = first_blk_q;
            end
            StRound: begin
                round_en  = 1'b1;
                round_idx = cnt;
                sel_W     = (32'(cnt) >= SCHED_WORDS);
            end
            StFinal: begin
                h_update = 1'b1;
                start    = 1'b1;
            end
            StDone:  digest_valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed self-checking bench for sha256_round_ctrl; the multi-block scenario is built only
// when SHA_CTRL_MULTIBLOCK_EN is defined.
module tb_sha256_round_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       blk_valid;
    logic       blk_ready;
`ifdef SHA_CTRL_MULTIBLOCK_EN
    logic       blk_last;
`endif
    logic       start;
    logic       sel_A;
    logic       h_init;
    logic       round_en;
    logic [5:0] round_idx;
    logic       sel_W;
    logic       h_update;
    logic       digest_valid;
    logic       out_ready;

    int n_asserts = 0;
    int n_fails   = 0;

    // Output vector order: {blk_ready,start,sel_A,h_init,round_en,sel_W,h_update,digest_valid}
    localparam logic [7:0] OIdle     = 8'h80;
    localparam logic [7:0] OInitH    = 8'h70;
    localparam logic [7:0] OInitNoH  = 8'h60;
    localparam logic [7:0] ORndMsg   = 8'h08;
    localparam logic [7:0] ORndExp   = 8'h0C;
    localparam logic [7:0] OFinal    = 8'h42;
    localparam logic [7:0] ODone     = 8'h01;

    sha256_round_ctrl dut (
        .CLK          (CLK),
        .RST          (RST),
        .blk_valid    (blk_valid),
        .blk_ready    (blk_ready),
`ifdef SHA_CTRL_MULTIBLOCK_EN
        .blk_last     (blk_last),
`endif
        .start        (start),
        .sel_A        (sel_A),
        .h_init       (h_init),
        .round_en     (round_en),
        .round_idx    (round_idx),
        .sel_W        (sel_W),
        .h_update     (h_update),
        .digest_valid (digest_valid),
        .out_ready    (out_ready)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] outs();
        return {blk_ready, start, sel_A, h_init, round_en, sel_W, h_update, digest_valid};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered in IDLE; leaves the bench at the FINAL cycle after checking every step.
    task automatic run_block(input string tag, input logic hinit_exp, input logic noise);
        chk({tag, " idle"}, 32'(outs()), 32'(OIdle));
        blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        chk({tag, " init"}, 32'(outs()), 32'(hinit_exp ? OInitH : OInitNoH));
        for (int t = 0; t < 64; t++) begin
            tick();
            blk_valid = (noise && (t >= 10) && (t <= 13)) ? 1'b1 : 1'b0;
            chk({tag, " round outs"}, 32'(outs()), 32'((t < 16) ? ORndMsg : ORndExp));
            chk({tag, " round_idx"}, 32'(round_idx), 32'(t));
        end
        blk_valid = 1'b0;
        tick();
        chk({tag, " final"}, 32'(outs()), 32'(OFinal));
    endtask

    initial begin
        int cnt;
        RST       = 1'b0;
        blk_valid = 1'b0;
        out_ready = 1'b0;
`ifdef SHA_CTRL_MULTIBLOCK_EN
        blk_last  = 1'b1;
`endif
        tick();
        tick();
        chk("reset outs", 32'(outs()), 32'(OIdle));
        chk("reset idx", 32'(round_idx), 32'd0);
        RST = 1'b1;
        tick();
        chk("idle stays", 32'(outs()), 32'(OIdle));

        // Single block, then a held DONE with consumer stalled.
        run_block("blk1", 1'b1, 1'b0);
        tick();
        chk("done first", 32'(outs()), 32'(ODone));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("done held", 32'(outs()), 32'(ODone));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("after done idle", 32'(outs()), 32'(OIdle));

        // blk_valid noise during rounds is ignored; out_ready on first DONE cycle.
        run_block("noise", 1'b1, 1'b1);
        out_ready = 1'b1;
        tick();
        chk("done 1cyc", 32'(outs()), 32'(ODone));
        tick();
        out_ready = 1'b0;
        chk("idle after 1cyc", 32'(outs()), 32'(OIdle));

        // Reset in the middle of the round sequence.
        blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
        for (int i = 0; i <= 30; i++) tick();
        chk("mid idx30", 32'(round_idx), 32'd30);
        RST = 1'b0;
        tick();
        RST = 1'b1;
        chk("midrst outs", 32'(outs()), 32'(OIdle));
        chk("midrst idx", 32'(round_idx), 32'd0);
        run_block("post rst", 1'b1, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("post rst done", 32'(outs()), 32'(ODone));
        tick();
        out_ready = 1'b0;

`ifdef SHA_CTRL_MULTIBLOCK_EN
        blk_last = 1'b0;
        run_block("mb A", 1'b1, 1'b0);
        blk_last = 1'b1;
        tick();
        chk("mb A idle no digest", 32'(outs()), 32'(OIdle));
        run_block("mb B", 1'b0, 1'b0);
        tick();
        chk("mb B done", 32'(outs()), 32'(ODone));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("mb B idle", 32'(outs()), 32'(OIdle));
`endif

        // Back-to-back throughput.
        out_ready = 1'b1;
        blk_valid = 1'b1;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!(start && sel_A) && cnt < 200);
        chk("b2b first init", 32'(start && sel_A), 32'd1);
        for (int b = 0; b < 2; b++) begin
            cnt = 0;
            do begin
                tick();
                cnt++;
            end while (!(start && sel_A) && cnt < 200);
            chk("b2b period", 32'(cnt), 32'd68);
        end
        blk_valid = 1'b0;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!blk_ready && cnt < 200);
        chk("b2b drain idle", 32'(outs()), 32'(OIdle));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
